stage_mem: RTL and testbench
============================

Name: stage_mem

Overview:
Memory-access stage that directly consumes the EX-stage registered outputs (aluout, zero-qualified control) and produces registered write-back data.
- Non-memory ops: aluout passes through with one-cycle latency.
- Loads and stores: drives a variable-latency data-memory req/ack interface, stalls upstream until the access completes, and performs byte-lane steering, sign/zero extension and a watchdog timeout.

Parameters:
ADDR_W, 32, address width of aluout and dmem_addr.
TIMEOUT, 16, maximum cycles to wait for dmem_ack before aborting (must be >= 1).
CNT_W, 5, width of timeout counter (must hold TIMEOUT).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  EX result valid this cycle.
aluout  in  ADDR_W  ALU result / effective address from EX.
store_data  in  32  rs2 value for stores.
memread  in  1  load op.
memwrite  in  1  store op; memread and memwrite are never both 1.
funct3  in  3  access size/sign.
rd  in  5  destination register.
regwrite  in  1  write-back enable.
stall  out  1  upstream must hold all inputs stable while 1.
dmem_req  out  1  memory request.
dmem_we  out  1  1 = write.
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0).
dmem_wdata  out  32  lane-replicated store data.
dmem_be  out  4  byte enables.
dmem_ack  in  1  single-cycle completion pulse; dmem_rdata valid with it.
dmem_rdata  in  32  read word.
wb_valid  out  1  write-back payload valid.
wb_data  out  32  load data or passed aluout.
wb_rd  out  5  registered rd.
wb_regwrite  out  1  registered regwrite (forced 0 on abort).
bus_err  out  1  one-cycle pulse with wb_valid when the access timed out.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, counter=0, all outputs 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - in_valid and neither memread nor memwrite: next cycle wb_valid=1, wb_data=aluout, wb_rd/wb_regwrite registered; stall=0.
  - in_valid and (memread or memwrite): stall=1 combinationally; capture address, data, funct3, rd, regwrite, op type; go to ACCESS; wb_valid=0 next cycle.
  - in_valid=0: wb_valid=0 next cycle.
- ACCESS:
  - dmem_req=1, driven only from captured registers.
  - stall = ~dmem_ack; the upstream stage advances on the ack cycle.
  - Counter increments each cycle without ack.
- On dmem_ack:
  - Next cycle: wb_valid=1, state=IDLE.
  - Loads: wb_data = extracted rdata.
  - Stores: wb_data=aluout and wb_regwrite=0.
  - Minimum memory-op latency is 2 cycles from in_valid to wb_valid.
- Timeout: counter reaching TIMEOUT with no ack → drop dmem_req, state=IDLE, next cycle wb_valid=1, bus_err=1, wb_regwrite=0, wb_data=0. An ack arriving on the same cycle wins over the timeout.
- Inputs presented in IDLE on the cycle ACCESS exits are accepted normally (back-to-back memory ops allowed).
- Load extraction by funct3, lane = addr[1:0]:
  - 000 LB: sign-extend byte.
  - 100 LBU: zero-extend byte.
  - 001 LH: sign-extend half at addr[1].
  - 101 LHU: zero-extend half at addr[1].
  - 010 LW: full word.
  - 011/110/111: treated as LW.
- Stores:
  - SB: be = 0001<<lane, wdata = byte replicated ×4.
  - SH: be = 0011<<(2*addr[1]), wdata = half replicated ×2.
  - SW: be = 1111.
  - Loads: be = 1111, we=0.
- Misaligned half/word without the optional feature: addr[0] (and addr[1] for word) ignored.
- Reset during ACCESS: request dropped immediately at that edge, no wb_valid produced.

Optional Feature:
STAGE_MEM_ALIGN_CHECK_EN
- Defined:
  - Output port misalign (1 bit) is added.
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, never enter ACCESS and issue no dmem_req.
  - Next cycle: wb_valid=1, misalign=1, wb_regwrite=0; stall=0.
- Undefined: port absent; misaligned addresses are silently aligned as above.

Decomposition:
- Package stage_mem_pkg:
  - funct3 encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - FSM state enum.
  - Byte-enable constants.
- One natural sub-module: mem_align_unit (combinational load extract / store steer), shared by both directions.

Test Plan:
- ALU op: in_valid=1, aluout=0x1234, regwrite=1, rd=5 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall stays 0.
- LB lane 3: aluout=0x103, rdata=0x80FF_0000, ack after 3 wait cycles → stall high 4 cycles, wb_data=0xFFFF_FF80.
- LHU addr 0x102: rdata=0xBEEF_0000, immediate ack → wb_data=0x0000_BEEF at 2-cycle latency.
- SB addr 0x201, store_data=0xAB → dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_addr=0x200, wb_regwrite=0.
- No ack for TIMEOUT=16 cycles → req drops, wb_valid=1 with bus_err=1, wb_regwrite=0; then a back-to-back LW completes normally.
- rst_n=0 mid-ACCESS → dmem_req=0 and all outputs 0 after that edge; with STAGE_MEM_ALIGN_CHECK_EN, LW at 0x2 → misalign=1 with no dmem_req.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states,
// byte-enable constants and access-size helpers.
package stage_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Size comes from funct3[1:0]; every encoding not byte/half is a word access.
  function automatic size_t f3_size(input logic [1:0] f3_lo);
    size_t sz;
    if (f3_lo == F3_LB[1:0])      sz = SZ_BYTE;
    else if (f3_lo == F3_LH[1:0]) sz = SZ_HALF;
    else                          sz = SZ_WORD;
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] f3_lo, input logic [1:0] lane);
    logic mis;
    case (f3_size(f3_lo))
      SZ_HALF: mis = lane[0];
      SZ_WORD: mis = |lane;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/stage_mem_align.sv
// mem_align_unit: combinational byte-lane steering for stores and
// lane extraction with sign/zero extension for loads.
module mem_align_unit
  import stage_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  size_t       w_size;
  logic        w_sext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size = f3_size(i_funct3[1:0]);
    w_sext = ~i_funct3[2];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase

    o_load_data = i_rdata;
    o_be        = BE_ALL;
    o_wdata     = i_store_data;

    case (w_size)
      SZ_BYTE: begin
        o_load_data = {{24{w_sext & w_byte[7]}}, w_byte};
        if (i_is_store) begin
          o_be    = BE_B0 << i_lane;
          o_wdata = {4{i_store_data[7:0]}};
        end
      end
      SZ_HALF: begin
        o_load_data = {{16{w_sext & w_half[15]}}, w_half};
        if (i_is_store) begin
          o_be    = i_lane[1] ? BE_HALF_HI : BE_HALF_LO;
          o_wdata = {2{i_store_data[15:0]}};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: ALU results pass through in one cycle, loads and
// stores run a req/ack data-memory handshake with watchdog. Option: STAGE_MEM_ALIGN_CHECK_EN.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] aluout,
  input  logic [31:0]       store_data,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic              regwrite,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_regwrite,
`ifdef STAGE_MEM_ALIGN_CHECK_EN
  output logic              misalign,
`endif
  output logic              bus_err
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_sdata;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_regwrite;
  logic              r_is_store;
  logic              r_wb_valid;
  logic [31:0]       r_wb_data;
  logic [4:0]        r_wb_rd;
  logic              r_wb_regwrite;
  logic              r_bus_err;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
  logic              r_misalign;
`endif

  logic        w_mem_op;
  logic        w_misal;
  logic        w_accept_mem;
  logic        w_in_access;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_mem_op = memread | memwrite;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
  assign w_misal = w_mem_op & is_misaligned(funct3[1:0], aluout[1:0]);
`else
  assign w_misal = 1'b0;
`endif
  assign w_accept_mem = in_valid & w_mem_op & ~w_misal;
  assign w_in_access  = (r_state == S_ACCESS);
  assign w_timeout    = w_in_access & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));

  mem_align_unit u_align (
    .i_funct3     (r_funct3),
    .i_lane       (r_addr[1:0]),
    .i_is_store   (r_is_store),
    .i_store_data (r_sdata),
    .i_rdata      (dmem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // A timed-out access also releases upstream; otherwise the aborted op would reissue.
  always_comb begin
    stall = 1'b0;
    if (w_in_access) stall = ~(dmem_ack | w_timeout);
    else             stall = w_accept_mem;
  end

  assign dmem_req   = w_in_access;
  assign dmem_we    = w_in_access & r_is_store;
  assign dmem_addr  = w_in_access ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_wdata = w_in_access ? w_wdata : '0;
  assign dmem_be    = w_in_access ? (r_is_store ? w_be : BE_ALL) : BE_NONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_sdata       <= '0;
      r_funct3      <= '0;
      r_rd          <= '0;
      r_regwrite    <= 1'b0;
      r_is_store    <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_bus_err     <= 1'b0;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
      r_bus_err  <= 1'b0;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_misal) begin
              r_wb_valid    <= 1'b1;
              r_wb_data     <= 32'(aluout);
              r_wb_rd       <= rd;
              r_wb_regwrite <= 1'b0;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
              r_misalign    <= 1'b1;
`endif
            end else if (w_mem_op) begin
              r_state    <= S_ACCESS;
              r_cnt      <= '0;
              r_addr     <= aluout;
              r_sdata    <= store_data;
              r_funct3   <= funct3;
              r_rd       <= rd;
              r_regwrite <= regwrite;
              r_is_store <= memwrite;
            end else begin
              r_wb_valid    <= 1'b1;
              r_wb_data     <= 32'(aluout);
              r_wb_rd       <= rd;
              r_wb_regwrite <= regwrite;
            end
          end
        end
        S_ACCESS: begin
          if (dmem_ack) begin
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= r_rd;
            r_wb_data     <= r_is_store ? 32'(r_addr) : w_load_data;
            r_wb_regwrite <= r_is_store ? 1'b0 : r_regwrite;
          end else if (w_timeout) begin
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b1;
            r_wb_rd       <= r_rd;
            r_wb_data     <= '0;
            r_wb_regwrite <= 1'b0;
            r_bus_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_data     = r_wb_data;
  assign wb_rd       = r_wb_rd;
  assign wb_regwrite = r_wb_regwrite;
  assign bus_err     = r_bus_err;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
  assign misalign    = r_misalign;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: randomized ALU/load/store traffic against
// an arithmetic reference model, plus timeout, reset and alignment scenarios.
module tb_stage_mem;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] aluout = '0;
  logic [31:0] store_data = '0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        regwrite = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic        stall, dmem_req, dmem_we, wb_valid, wb_regwrite, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  stage_mem #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .aluout      (aluout),
    .store_data  (store_data),
    .memread     (memread),
    .memwrite    (memwrite),
    .funct3      (funct3),
    .rd          (rd),
    .regwrite    (regwrite),
    .stall       (stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    .misalign    (misalign),
`endif
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: access size in bytes from funct3
  function automatic int unsigned m_size(input logic [2:0] f3);
    int unsigned lo = int'(f3) % 4;
    return (lo == 0) ? 1 : (lo == 1) ? 2 : 4;
  endfunction

  function automatic int unsigned m_off(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = m_size(f3);
    return ((addr % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] w);
    int unsigned sz = m_size(f3);
    logic [31:0] v;
    v = w >> (8 * m_off(f3, addr));
    if (sz < 4) begin
      v = v % (32'd1 << (8 * sz));
      if (f3 < 3'd4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = m_size(f3);
    return 4'(((1 << sz) - 1) << m_off(f3, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int unsigned sz = m_size(f3);
    logic [31:0] r;
    if (sz == 1)      r = (sd % 256) * 32'h0101_0101;
    else if (sz == 2) r = (sd % 65536) * 32'h0001_0001;
    else              r = sd;
    return r;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % m_size(f3)) != 0;
  endfunction

  task automatic drive_alu(input string tag, input logic [31:0] val, input logic [4:0] rd_i,
                           input logic rw_i);
    in_valid = 1'b1; aluout = val; memread = 1'b0; memwrite = 1'b0;
    rd = rd_i; regwrite = rw_i; funct3 = 3'($urandom);
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL %s stall: got %0b want 0", tag, stall);
    end
    @(negedge clk);
    n_checks++;
    if ({wb_valid, wb_data, wb_rd, wb_regwrite, bus_err, dmem_req} !==
        {1'b1, val, rd_i, rw_i, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s wb: got v=%0b d=%h rd=%0d rw=%0b err=%0b req=%0b want v=1 d=%h rd=%0d rw=%0b err=0 req=0",
               tag, wb_valid, wb_data, wb_rd, wb_regwrite, bus_err, dmem_req, val, rd_i, rw_i);
    end
    in_valid = 1'b0;
  endtask

  // waits >= TIMEOUT means the memory never acknowledges
  task automatic drive_mem_op(input string tag, input bit is_load, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] rd_i, input logic rw_i,
                              input int unsigned waits, input logic [31:0] rdata_i);
    bit acked = 0;
    int unsigned stall_cnt = 0;
    int unsigned exp_stall_cnt;
    logic [31:0] exp_data;
    in_valid = 1'b1; aluout = addr; store_data = sdata; memread = is_load;
    memwrite = !is_load; funct3 = f3; rd = rd_i; regwrite = rw_i; dmem_ack = 1'b0;
    #1;
`ifdef STAGE_MEM_ALIGN_CHECK_EN
    if (m_misal(f3, addr)) begin
      n_checks++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL %s misalign stall: got %0b want 0", tag, stall);
      end
      @(negedge clk);
      n_checks++;
      if ({wb_valid, misalign, wb_regwrite, dmem_req, bus_err, wb_rd} !==
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rd_i}) begin
        n_fail++;
        $display("FAIL %s misalign wb: got v=%0b mis=%0b rw=%0b req=%0b err=%0b rd=%0d want 1 1 0 0 0 %0d",
                 tag, wb_valid, misalign, wb_regwrite, dmem_req, bus_err, wb_rd, rd_i);
      end
      in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
      return;
    end
`endif
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL %s issue stall: got %0b want 1", tag, stall);
    end
    if (stall === 1'b1) stall_cnt++;
    for (int unsigned cyc = 0; cyc < TIMEOUT && !acked; cyc++) begin
      @(negedge clk);
      dmem_ack = 1'b0;
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be} !==
          {1'b1, !is_load, addr & 32'hFFFF_FFFC, is_load ? 4'hF : m_be(f3, addr)}) begin
        n_fail++;
        $display("FAIL %s req cyc%0d: got req=%0b we=%0b a=%h be=%b want 1 %0b %h %b", tag, cyc,
                 dmem_req, dmem_we, dmem_addr, dmem_be, !is_load, addr & 32'hFFFF_FFFC,
                 is_load ? 4'hF : m_be(f3, addr));
      end
      if (!is_load) begin
        n_checks++;
        if (dmem_wdata !== m_wdata(f3, sdata)) begin
          n_fail++; $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, m_wdata(f3, sdata));
        end
      end
      if (cyc == waits) begin
        dmem_ack = 1'b1; dmem_rdata = rdata_i; acked = 1;
      end else begin
        dmem_rdata = $urandom;
      end
      #1;
      n_checks++;
      if (stall !== !(acked || cyc == TIMEOUT - 1)) begin
        n_fail++; $display("FAIL %s stall cyc%0d: got %0b want %0b", tag, cyc, stall,
                           !(acked || cyc == TIMEOUT - 1));
      end
      if (stall === 1'b1) stall_cnt++;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    exp_data = !acked ? 32'h0 : is_load ? m_load(f3, addr, rdata_i) : addr;
    exp_stall_cnt = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
    n_checks++;
    if (stall_cnt != exp_stall_cnt) begin
      n_fail++; $display("FAIL %s stall cycles: got %0d want %0d", tag, stall_cnt, exp_stall_cnt);
    end
    n_checks++;
    if ({wb_valid, wb_data, wb_rd, wb_regwrite, bus_err, dmem_req} !==
        {1'b1, exp_data, rd_i, acked && is_load && rw_i, !acked, 1'b0}) begin
      n_fail++;
      $display("FAIL %s wb: got v=%0b d=%h rd=%0d rw=%0b err=%0b req=%0b want v=1 d=%h rd=%0d rw=%0b err=%0b req=0",
               tag, wb_valid, wb_data, wb_rd, wb_regwrite, bus_err, dmem_req, exp_data, rd_i,
               acked && is_load && rw_i, !acked);
    end
    in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data,
         wb_rd, wb_regwrite, bus_err} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got req=%0b wbv=%0b wbd=%h be=%b want all 0",
                         dmem_req, wb_valid, wb_data, dmem_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    drive_alu("alu_0x1234", 32'h1234, 5'd5, 1'b1);
    for (int i = 0; i < 6; i++) drive_alu("alu_stream", $urandom, 5'($urandom), 1'($urandom));
    @(negedge clk);
    n_checks++;
    if (wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle wb_valid: got %0b want 0", wb_valid);
    end
  endtask

  task automatic test_load();
    drive_mem_op("lb_lane3", 1, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 3, 32'h80FF_0000);
    n_checks++;
    if (wb_data !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_lane3 const: got %h want ffffff80", wb_data);
    end
    drive_mem_op("lhu_0x102", 1, 3'b101, 32'h102, 32'h0, 5'd8, 1'b1, 0, 32'hBEEF_0000);
    n_checks++;
    if (wb_data !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL lhu_0x102 const: got %h want 0000beef", wb_data);
    end
  endtask

  task automatic test_store();
    drive_mem_op("sb_0x201", 0, 3'b000, 32'h201, 32'h0000_00AB, 5'd9, 1'b1, 1, 32'h0);
    drive_mem_op("sh_0x206", 0, 3'b001, 32'h206, 32'h1234_5678, 5'd10, 1'b1, 0, 32'h0);
    drive_mem_op("sw_0x20c", 0, 3'b010, 32'h20C, 32'hCAFE_F00D, 5'd11, 1'b1, 2, 32'h0);
  endtask

  task automatic test_back_to_back();
    drive_mem_op("lw_timeout", 1, 3'b010, 32'h300, 32'h0, 5'd12, 1'b1, TIMEOUT, 32'h0);
    drive_mem_op("lw_after_to", 1, 3'b010, 32'h304, 32'h0, 5'd13, 1'b1, 2, 32'h1357_9BDF);
    drive_mem_op("lh_b2b", 1, 3'b001, 32'h30A, 32'h0, 5'd14, 1'b1, 0, 32'h8001_7FFF);
    drive_alu("alu_b2b", 32'hDEAD_BEEF, 5'd15, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int unsigned kind = $urandom_range(0, 2);
      int unsigned waits = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, 4);
      logic [31:0] a = $urandom;
      if (kind == 0) begin
        drive_alu("rnd_alu", a, 5'($urandom), 1'($urandom));
      end else if (kind == 1) begin
        drive_mem_op("rnd_load", 1, 3'($urandom), a, 32'h0, 5'($urandom), 1'($urandom),
                     waits, $urandom);
      end else begin
        drive_mem_op("rnd_store", 0, 3'($urandom_range(0, 2)), a, $urandom, 5'($urandom),
                     1'($urandom), waits, $urandom);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_access();
    in_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010;
    aluout = 32'h400; rd = 5'd3; regwrite = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid pre req: got %0b want 1", dmem_req);
    end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; memread = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_data,
         wb_rd, wb_regwrite, bus_err} !== '0) begin
      n_fail++; $display("FAIL rst_mid outputs: got req=%0b wbv=%0b be=%b want all 0",
                         dmem_req, wb_valid, dmem_be);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wb_valid, dmem_req} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid post: got wbv=%0b req=%0b want 0 0", wb_valid, dmem_req);
    end
  endtask

  task automatic test_misalign();
    drive_mem_op("lw_0x2", 1, 3'b010, 32'h2, 32'h0, 5'd4, 1'b1, 0, 32'h1111_2222);
    drive_mem_op("sh_0x3", 0, 3'b001, 32'h3, 32'hABCD, 5'd6, 1'b1, 1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_misalign();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
